// File: rtl/pipeline_ctrl_if.sv
// Stage-control bundle between the pipeline sequencer and the MIPS datapath:
// hazard/handshake/debug requests in, per-stage reset/enable pairs out.
interface pipeline_ctrl_if;
    logic reg_stall;
    logic branch_taken;
    logic mem_req;
    logic dmem_ack;
    logic dbg_halt;
    logic dbg_step;

    logic if_rst;
    logic id_rst;
    logic exe_rst;
    logic mem_rst;
    logic wb_rst;
    logic if_en;
    logic id_en;
    logic exe_en;
    logic mem_en;
    logic wb_en;

    modport master (
        input  reg_stall, branch_taken, mem_req, dmem_ack, dbg_halt, dbg_step,
        output if_rst, id_rst, exe_rst, mem_rst, wb_rst,
        output if_en, id_en, exe_en, mem_en, wb_en
    );

    modport slave (
        output reg_stall, branch_taken, mem_req, dmem_ack, dbg_halt, dbg_step,
        input  if_rst, id_rst, exe_rst, mem_rst, wb_rst,
        input  if_en, id_en, exe_en, mem_en, wb_en
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stage-control sequencer for the 5-stage pipeline: power-up reset hold,
// hazard/branch/memory-wait decisions, debug halt/step, perf counters.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   S_INIT     | all stages held in reset for RST_CYCLES cycles
//   S_RUN      | normal issue: mem wait > branch flush > load-use stall
//   S_MEM_WAIT | full freeze until dmem_ack or timeout
//   S_HALT     | frozen by debug, waiting for resume or single step
//   S_STEP     | one cycle of RUN rules, then back to HALT
module pipeline_ctrl #(
    parameter int RST_CYCLES  = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_ctrl_if.master      bus,
    output logic                 halted,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int INIT_W = $clog2(RST_CYCLES + 1);
    localparam int TMO_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(MEM_TIMEOUT - 1);

    // Stage vector bit order: 0=IF 1=ID 2=EXE 3=MEM 4=WB
    localparam logic [4:0] FLUSH_EN  = 5'b11001;
    localparam logic [4:0] FLUSH_RST = 5'b00110;
    localparam logic [4:0] STALL_EN  = 5'b11000;
    localparam logic [4:0] STALL_RST = 5'b00100;

    typedef enum logic [2:0] {
        S_INIT,
        S_RUN,
        S_MEM_WAIT,
        S_HALT,
        S_STEP
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        rst_q, rst_d;
    logic [4:0]        en_q, en_d;
    logic [INIT_W-1:0] init_q, init_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              timeout_d;
    logic              halted_d;
    logic              stall_inc;
    logic              flush_inc;
    logic              run_eval;
    logic              mem_ok;

    always_comb begin
        state_d   = state_q;
        rst_d     = '0;
        en_d      = '0;
        init_d    = init_q;
        tmo_d     = tmo_q;
        timeout_d = mem_timeout;
        halted_d  = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        run_eval  = 1'b0;
        mem_ok    = 1'b0;

        case (state_q)
            S_INIT: begin
                rst_d = '1;
                if (init_q == INIT_LAST) begin
                    state_d = bus.dbg_halt ? S_HALT : S_RUN;
                end else begin
                    init_d = init_q + 1'b1;
                end
            end
            S_RUN, S_STEP: begin
                run_eval = 1'b1;
            end
            S_MEM_WAIT: begin
                if (bus.dmem_ack) begin
                    run_eval = 1'b1;
                    mem_ok   = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    run_eval  = 1'b1;
                    mem_ok    = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_HALT: begin
                halted_d = 1'b1;
                if (!bus.dbg_halt) begin
                    state_d = S_RUN;
                end else if (bus.dbg_step) begin
                    state_d = S_STEP;
                end
            end
            default: begin
                state_d = S_INIT;
                rst_d   = '1;
            end
        endcase

        // Leaving MEM_WAIT counts as the access being satisfied, so the
        // still-asserted mem_req must not send us straight back into the wait.
        if (run_eval) begin
            if (bus.mem_req && !bus.dmem_ack && !mem_ok) begin
                state_d = S_MEM_WAIT;
                tmo_d   = '0;
            end else begin
                if (bus.branch_taken) begin
                    en_d      = FLUSH_EN;
                    rst_d     = FLUSH_RST;
                    flush_inc = 1'b1;
                end else if (bus.reg_stall) begin
                    en_d      = STALL_EN;
                    rst_d     = STALL_RST;
                    stall_inc = 1'b1;
                end else begin
                    en_d = '1;
                end
                state_d = (state_q == S_STEP || bus.dbg_halt) ? S_HALT : S_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            rst_q       <= '1;
            en_q        <= '0;
            init_q      <= '0;
            tmo_q       <= '0;
            halted      <= 1'b0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            rst_q       <= rst_d;
            en_q        <= en_d;
            init_q      <= init_d;
            tmo_q       <= tmo_d;
            halted      <= halted_d;
            mem_timeout <= timeout_d;
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.if_rst  = rst_q[0];
    assign bus.id_rst  = rst_q[1];
    assign bus.exe_rst = rst_q[2];
    assign bus.mem_rst = rst_q[3];
    assign bus.wb_rst  = rst_q[4];
    assign bus.if_en   = en_q[0];
    assign bus.id_en   = en_q[1];
    assign bus.exe_en  = en_q[2];
    assign bus.mem_en  = en_q[3];
    assign bus.wb_en   = en_q[4];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: default instance plus a second one with
// a 3-cycle memory timeout and 2-bit counters, both driven by the same inputs.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic reg_stall, branch_taken, mem_req, dmem_ack, dbg_halt, dbg_step;

    pipeline_ctrl_if ia ();
    pipeline_ctrl_if ib ();

    assign ia.reg_stall    = reg_stall;
    assign ia.branch_taken = branch_taken;
    assign ia.mem_req      = mem_req;
    assign ia.dmem_ack     = dmem_ack;
    assign ia.dbg_halt     = dbg_halt;
    assign ia.dbg_step     = dbg_step;
    assign ib.reg_stall    = reg_stall;
    assign ib.branch_taken = branch_taken;
    assign ib.mem_req      = mem_req;
    assign ib.dmem_ack     = dmem_ack;
    assign ib.dbg_halt     = dbg_halt;
    assign ib.dbg_step     = dbg_step;

    logic        a_halted, a_to, b_halted, b_to;
    logic [15:0] a_stall, a_flush;
    logic [1:0]  b_stall, b_flush;

    pipeline_ctrl dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (ia),
        .halted      (a_halted),
        .mem_timeout (a_to),
        .stall_cnt   (a_stall),
        .flush_cnt   (a_flush)
    );

    pipeline_ctrl #(.RST_CYCLES(4), .CNT_W(2), .MEM_TIMEOUT(3)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (ib),
        .halted      (b_halted),
        .mem_timeout (b_to),
        .stall_cnt   (b_stall),
        .flush_cnt   (b_flush)
    );

    always #5 clk = ~clk;

    // Vectors ordered {WB, MEM, EXE, ID, IF}
    logic [4:0] a_en, a_rst, b_en;
    assign a_en  = {ia.wb_en, ia.mem_en, ia.exe_en, ia.id_en, ia.if_en};
    assign a_rst = {ia.wb_rst, ia.mem_rst, ia.exe_rst, ia.id_rst, ia.if_rst};
    assign b_en  = {ib.wb_en, ib.mem_en, ib.exe_en, ib.id_en, ib.if_en};

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bursts;
        logic [4:0] exp_en;
        rst_n = 1'b1;
        {reg_stall, branch_taken, mem_req, dmem_ack, dbg_halt, dbg_step} = '0;
        #1 rst_n = 1'b0;
        repeat (3) cyc();

        chk("rst_rst", 32'(a_rst), 32'h1F);
        chk("rst_en", 32'(a_en), 32'h0);
        chk("rst_halted", 32'(a_halted), 32'h0);
        chk("rst_to", 32'(a_to), 32'h0);
        chk("rst_cnt", 32'({a_stall, a_flush}), 32'h0);

        // Power-up: resets held exactly 4 cycles after release
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("init_rst", 32'(a_rst), 32'h1F);
            chk("init_en", 32'(a_en), 32'h0);
        end
        cyc();
        chk("run_en", 32'(a_en), 32'h1F);
        chk("run_rst", 32'(a_rst), 32'h0);
        chk("run_cnt", 32'({a_stall, a_flush}), 32'h0);

        // Load-use stall
        reg_stall = 1'b1;
        cyc();
        chk("stall_en", 32'(a_en), 32'h18);
        chk("stall_rst", 32'(a_rst), 32'h04);
        chk("stall_cnt", 32'(a_stall), 32'd1);
        reg_stall = 1'b0;
        cyc();
        chk("post_stall_en", 32'(a_en), 32'h1F);
        chk("post_stall_rst", 32'(a_rst), 32'h0);

        // Branch wins over stall
        branch_taken = 1'b1;
        reg_stall    = 1'b1;
        cyc();
        chk("flush_en", 32'(a_en), 32'h19);
        chk("flush_rst", 32'(a_rst), 32'h06);
        chk("flush_cnt", 32'(a_flush), 32'd1);
        chk("flush_stall_cnt", 32'(a_stall), 32'd1);
        branch_taken = 1'b0;

        // Consecutive stalls; the 2-bit counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_run_cnt", 32'(a_stall), 32'(i + 2));
        end
        chk("b_stall_sat", 32'(b_stall), 32'd3);
        reg_stall = 1'b0;
        branch_taken = 1'b1;
        cyc();
        chk("flush2_cnt", 32'(a_flush), 32'd2);
        branch_taken = 1'b0;

        // Access acknowledged in the same cycle: no freeze
        mem_req  = 1'b1;
        dmem_ack = 1'b1;
        cyc();
        chk("mem_hit_en", 32'(a_en), 32'h1F);

        // Ack low for 5 cycles; instance b times out after 3 wait cycles
        dmem_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("wait_en", 32'(a_en), 32'h0);
            chk("wait_rst", 32'(a_rst), 32'h0);
            chk("wait_to", 32'(a_to), 32'h0);
            chk("b_wait_en", 32'(b_en), (k == 3) ? 32'h1F : 32'h0);
            chk("b_wait_to", 32'(b_to), (k >= 3) ? 32'h1 : 32'h0);
        end
        dmem_ack = 1'b1;
        cyc();
        chk("ack_en", 32'(a_en), 32'h1F);
        chk("ack_to", 32'(a_to), 32'h0);
        chk("b_to_sticky", 32'(b_to), 32'h1);
        mem_req  = 1'b0;
        dmem_ack = 1'b0;
        cyc();
        chk("resume_en", 32'(a_en), 32'h1F);

        // Debug halt and two single steps four cycles apart
        dbg_halt = 1'b1;
        cyc();
        chk("halt_last_en", 32'(a_en), 32'h1F);
        chk("halt_last_h", 32'(a_halted), 32'h0);
        cyc();
        chk("halt_en", 32'(a_en), 32'h0);
        chk("halt_h", 32'(a_halted), 32'h1);
        bursts = 0;
        for (int j = 0; j < 10; j++) begin
            dbg_step = (j == 0 || j == 4);
            cyc();
            exp_en = (j == 1 || j == 5) ? 5'h1F : 5'h0;
            chk("step_en", 32'(a_en), 32'(exp_en));
            chk("step_h", 32'(a_halted), (j == 1 || j == 5) ? 32'h0 : 32'h1);
            if (a_en != 5'h0) bursts++;
        end
        dbg_step = 1'b0;
        chk("step_bursts", 32'(bursts), 32'd2);
        dbg_halt = 1'b0;
        cyc();
        chk("unhalt_en", 32'(a_en), 32'h0);
        cyc();
        chk("unhalt_run_en", 32'(a_en), 32'h1F);
        chk("unhalt_h", 32'(a_halted), 32'h0);

        // Bring stall_cnt to 7, then reset in the middle of a memory wait
        reg_stall = 1'b1;
        repeat (3) cyc();
        reg_stall = 1'b0;
        chk("stall7", 32'(a_stall), 32'd7);
        mem_req = 1'b1;
        cyc();
        cyc();
        chk("mw_en", 32'(a_en), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", 32'(a_rst), 32'h1F);
        chk("async_en", 32'(a_en), 32'h0);
        chk("async_stall", 32'(a_stall), 32'h0);
        chk("async_flush", 32'(a_flush), 32'h0);
        chk("async_b_to", 32'(b_to), 32'h0);
        mem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("reinit_rst", 32'(a_rst), 32'h1F);
        end
        cyc();
        chk("rerun_en", 32'(a_en), 32'h1F);
        chk("rerun_rst", 32'(a_rst), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
